// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage. Owns the architectural
// HI/LO registers. A mult/multu/div/divu issued from IDLE computes its result
// into a pending register at once and commits it to HI/LO after a fixed
// latency. mthi/mtlo write directly. The busy flag lets the hazard unit
// stall MD-class instructions.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        start,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    // One-bit encoding so busy comes straight from the state flop.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [31:0]        hi_p, lo_p;
    logic               zero_p;      // pending divide had B==0: commit keeps HI/LO
    logic               commit;

    logic               issue;
    logic               is_div;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        a_mag, b_mag, div_a, div_b;
    logic [31:0]        quot_u, rem_u;
    logic [31:0]        quot_s, rem_s;

    assign issue  = md_valid & ~cancel;
    assign is_div = md_op[1];
    assign start  = issue & ~md_op[2] & (state == IDLE);
    assign busy   = (state == RUN);

    // Result datapath: both products, and one unsigned divider shared by
    // div (on operand magnitudes, signs fixed afterwards) and divu.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        a_mag  = A[31] ? -A : A;
        b_mag  = B[31] ? -B : B;
        div_a  = md_op[0] ? A : a_mag;
        div_b  = md_op[0] ? B : b_mag;
        if (div_b == 32'd0) begin
            div_b = 32'd1;           // result is discarded; avoid divide by zero
        end
        quot_u = div_a / div_b;
        rem_u  = div_a % div_b;
        // 0x80000000 / -1: magnitude quotient 2^31 with equal signs wraps back
        // to 0x80000000 and the remainder is 0, which is the wanted result.
        quot_s = (A[31] ^ B[31]) ? -quot_u : quot_u;
        rem_s  = A[31] ? -rem_u : rem_u;
    end

    // Next-state logic: load the latency counter on issue, count down in RUN,
    // and commit on the edge where the counter reaches zero.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_next   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Pending result capture at issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_p   <= '0;
            lo_p   <= '0;
            zero_p <= 1'b0;
        end else if (start) begin
            case (md_op[1:0])
                2'b00:   {hi_p, lo_p} <= prod_s;
                2'b01:   {hi_p, lo_p} <= prod_u;
                2'b10:   {hi_p, lo_p} <= {rem_s, quot_s};
                default: {hi_p, lo_p} <= {rem_u, quot_u};
            endcase
            zero_p <= is_div & (B == 32'd0);
        end
    end

    // Architectural HI/LO: commit from pending, or direct mthi/mtlo in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HI <= '0;
            LO <= '0;
        end else if (commit) begin
            if (!zero_p) begin
                HI <= hi_p;
                LO <= lo_p;
            end
        end else if (issue && state == IDLE) begin
            if (md_op == OP_MTHI) HI <= A;
            if (md_op == OP_MTLO) LO <= A;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed issues push expected HI/LO and commit cycle
// into a scoreboard; a monitor pops and compares on every busy falling edge.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        md_valid;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] A, B;
    logic        busy, start;
    logic [31:0] HI, LO;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .md_valid(md_valid), .md_op(md_op),
        .cancel(cancel), .A(A), .B(B), .busy(busy), .start(start),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   issue_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one issue across a single clock edge; checks start beforehand.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic exp_start);
        @(negedge clk);
        md_valid = 1'b1; md_op = op; A = a; B = b; cancel = c;
        #1 check("start", {31'd0, start}, {31'd0, exp_start});
        @(posedge clk);
        #1;
        issue_cyc = cyc;
        md_valid = 1'b0; cancel = 1'b0;
    endtask

    task automatic expect_commit(input logic [31:0] hi, input logic [31:0] lo, input int lat);
        exp_t e;
        e.hi = hi; e.lo = lo; e.due = issue_cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: every busy falling edge outside reset is a commit.
    initial begin : monitor
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (sb.size() == 0) begin
                        check("unexpected_commit", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("commit_hi", HI, e.hi);
                        check("commit_lo", LO, e.lo);
                        check("commit_cycle", 32'(cyc), 32'(e.due));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        md_valid = 1'b0; md_op = 3'b000; cancel = 1'b0; A = '0; B = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_start", {31'd0, start}, 32'd0);
        reset_n = 1'b1;

        // mult -2 * 3 = -6, busy for exactly 5 cycles
        issue(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
        expect_commit(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy || n >= 50) break;
            n++;
        end
        check("mult_busy_cycles", 32'(n), 32'd5);

        // divu 100/7, then signed -7/2 as soon as the unit frees up
        issue(3'b011, 32'd100, 32'd7, 1'b0, 1'b1);
        expect_commit(32'd2, 32'd14, 10);
        wait_idle();
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        expect_commit(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_idle();

        // mthi / mtlo on consecutive edges
        issue(3'b100, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        check("mthi_hi", HI, 32'h0000_1234);
        issue(3'b101, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
        check("mtlo_lo", LO, 32'h0000_5678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        // divide by zero keeps HI/LO
        issue(3'b010, 32'd55, 32'd0, 1'b0, 1'b1);
        expect_commit(32'h0000_1234, 32'h0000_5678, 10);
        wait_idle();

        // signed overflow
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        expect_commit(32'h0000_0000, 32'h8000_0000, 10);
        wait_idle();

        // reserved op: nothing happens
        issue(3'b110, 32'h0000_AAAA, 32'h0000_BBBB, 1'b0, 1'b0);
        @(negedge clk);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        check("rsvd_hi", HI, 32'h0000_0000);
        check("rsvd_lo", LO, 32'h8000_0000);

        // cancelled multu: no start, no busy, HI/LO unchanged
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_hi", HI, 32'h0000_0000);
        check("cancel_lo", LO, 32'h8000_0000);

        // mult 7 * -3 = -21 with an mtlo attempted during RUN
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1);
        expect_commit(32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        issue(3'b101, 32'h0000_DEAD, 32'd0, 1'b0, 1'b0);
        check("run_mtlo_ignored", LO, 32'h8000_0000);
        check("run_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // asynchronous reset in the middle of a divide
        issue(3'b010, 32'd100, 32'd3, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("stale_busy", {31'd0, busy}, 32'd0);
            check("stale_hi", HI, 32'd0);
            check("stale_lo", LO, 32'd0);
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
